// File: rtl/pc_fetch_unit_if.sv
// Program-memory fetch port.
//   pm_addr  : fetch address driven by the fetch unit (always the PC)
//   pm_req   : fetch request from the fetch unit
//   pm_rdata : instruction word returned for pm_addr
//   pm_ready : pm_rdata is valid this cycle
// The master modport belongs to the fetch unit and the slave modport to program memory.
interface pc_fetch_unit_if #(
  parameter int INSTR_W = 24
);
  logic [15:0]        pm_addr;
  logic               pm_req;
  logic [INSTR_W-1:0] pm_rdata;
  logic               pm_ready;

  modport master (
    output pm_addr,
    output pm_req,
    input  pm_rdata,
    input  pm_ready
  );

  modport slave (
    input  pm_addr,
    input  pm_req,
    output pm_rdata,
    output pm_ready
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter / instruction-fetch stage.
// Holds the PC, requests instructions from program memory and latches the
// returned word into the instruction register (IR). The IR is exported to the
// jump-control stage, and that stage's redirect (pc_mux_sel/jmp_loc) reloads
// the PC and flushes the IR.
// Ports:
//   clk             : clock, all state changes on the rising edge
//   reset           : synchronous, active-low
//   pm              : program-memory fetch port (master side)
//   jmp_loc         : redirect target
//   pc_mux_sel      : redirect request
//   stall           : hazard stall from decode
//   instr           : IR contents
//   instr_valid     : IR holds a live instruction
//   op              : IR opcode, zero while the IR is not valid
//   jmp_address_pm  : jump target field of the IR
//   current_address : address the IR was fetched from
module pc_fetch_unit #(
  parameter int          INSTR_W      = 24,
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          BOOT_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  pc_fetch_unit_if.master       pm,
  input  logic [15:0]           jmp_loc,
  input  logic                  pc_mux_sel,
  input  logic                  stall,
  output logic [INSTR_W-1:0]    instr,
  output logic                  instr_valid,
  output logic [5:0]            op,
  output logic [15:0]           jmp_address_pm,
  output logic [15:0]           current_address
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] BOOT_LAST = 2'(BOOT_CYCLES - 1);

  // An invalid or flushed IR must decode as opcode 000000 so it can never
  // look like a jump to the downstream stage.
  function automatic logic [5:0] gate_op(input logic vld, input logic [INSTR_W-1:0] ir);
    return vld ? ir[INSTR_W-1 -: 6] : 6'b000000;
  endfunction

  state_t             state_q;
  state_t             state_d;
  logic [1:0]         boot_cnt_q;
  logic [1:0]         boot_cnt_d;
  logic               fetch_req;

  logic [15:0]        pc_p0;
  logic [INSTR_W-1:0] ir_p1;
  logic [15:0]        cur_addr_p1;
  logic               vld_p1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= BOOT;
      boot_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    case (state_q)
      BOOT: begin
        // A redirect during BOOT does not shorten it; only the counter moves us on.
        boot_cnt_d = boot_cnt_q + 2'd1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Memory is a stateless read port, so dropping the request mid-wait is safe.
  assign fetch_req = (state_q == RUN) && !stall && !pc_mux_sel;

  // Stage p0 -> p1: PC issues the fetch, IR captures the returned word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_p0       <= RESET_VECTOR;
      ir_p1       <= '0;
      cur_addr_p1 <= 16'h0000;
      vld_p1      <= 1'b0;
    end else if (pc_mux_sel) begin
      pc_p0  <= jmp_loc;
      vld_p1 <= 1'b0;
    end else if (stall) begin
      pc_p0  <= pc_p0;
      vld_p1 <= vld_p1;
    end else if (state_q == RUN) begin
      if (pm.pm_ready) begin
        ir_p1       <= pm.pm_rdata;
        cur_addr_p1 <= pc_p0;
        vld_p1      <= 1'b1;
        pc_p0       <= pc_p0 + 16'd1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign pm.pm_addr      = pc_p0;
  assign pm.pm_req       = fetch_req;
  assign instr           = ir_p1;
  assign instr_valid     = vld_p1;
  assign op              = gate_op(vld_p1, ir_p1);
  assign jmp_address_pm  = ir_p1[15:0];
  assign current_address = cur_addr_p1;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
  localparam int          INSTR_W     = 24;
  localparam logic [15:0] RV          = 16'h0000;
  localparam int          BOOT_CYCLES = 2;

  typedef struct {
    logic               req;
    logic [15:0]        addr;
    logic [INSTR_W-1:0] ir;
    logic               vld;
    logic [5:0]         op;
    logic [15:0]        jmp;
    logic [15:0]        ca;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic [15:0]        jmp_loc;
  logic               pc_mux_sel;
  logic               stall;
  logic               ready_drv;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [5:0]         op;
  logic [15:0]        jmp_address_pm;
  logic [15:0]        current_address;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];

  // Model state
  logic [15:0]        m_pc;
  logic [INSTR_W-1:0] m_ir;
  logic [15:0]        m_ca;
  logic               m_vld;
  int                 m_boot_left;
  bit                 m_init = 1'b0;

  // Program memory contents: a fixed function of the address.
  function automatic logic [INSTR_W-1:0] memf(input logic [15:0] a);
    return {a[15:10] ^ 6'h2A, a[1:0], a ^ 16'h1234};
  endfunction

  pc_fetch_unit_if #(.INSTR_W(INSTR_W)) pm_if ();

  assign pm_if.pm_rdata = memf(pm_if.pm_addr);
  assign pm_if.pm_ready = ready_drv;

  pc_fetch_unit #(
    .INSTR_W(INSTR_W),
    .RESET_VECTOR(RV),
    .BOOT_CYCLES(BOOT_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pm(pm_if.master),
    .jmp_loc(jmp_loc),
    .pc_mux_sel(pc_mux_sel),
    .stall(stall),
    .instr(instr),
    .instr_valid(instr_valid),
    .op(op),
    .jmp_address_pm(jmp_address_pm),
    .current_address(current_address)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, req, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the oldest expectation each cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pm_req",          32'(pm_if.pm_req),    32'(e.req));
      chk("pm_addr",         32'(pm_if.pm_addr),   32'(e.addr));
      chk("instr",           32'(instr),           32'(e.ir));
      chk("instr_valid",     32'(instr_valid),     32'(e.vld));
      chk("op",              32'(op),              32'(e.op));
      chk("jmp_address_pm",  32'(jmp_address_pm),  32'(e.jmp));
      chk("current_address", 32'(current_address), 32'(e.ca));
    end
  end

  // One clock cycle: drive inputs, record the expected outputs for this cycle,
  // then advance the reference model across the rising edge.
  task automatic cycle(input bit r, input bit st, input bit sel,
                       input logic [15:0] jl, input bit rdy);
    exp_t e;
    bit   running;
    reset      = r;
    stall      = st;
    pc_mux_sel = sel;
    jmp_loc    = jl;
    ready_drv  = rdy;
    if (m_init) begin
      e.req  = (m_boot_left == 0) && !st && !sel;
      e.addr = m_pc;
      e.ir   = m_ir;
      e.vld  = m_vld;
      e.op   = m_vld ? m_ir[INSTR_W-1:INSTR_W-6] : 6'd0;
      e.jmp  = m_ir[15:0];
      e.ca   = m_ca;
      sb.push_back(e);
    end
    @(posedge clk);
    if (!r) begin
      m_pc        = RV;
      m_ir        = '0;
      m_ca        = 16'h0000;
      m_vld       = 1'b0;
      m_boot_left = BOOT_CYCLES;
      m_init      = 1'b1;
    end else begin
      running = (m_boot_left == 0);
      if (sel) begin
        m_pc  = jl;
        m_vld = 1'b0;
      end else if (!st && running) begin
        if (rdy) begin
          m_ir  = memf(m_pc);
          m_ca  = m_pc;
          m_vld = 1'b1;
          m_pc  = m_pc + 16'd1;
        end else begin
          m_vld = 1'b0;
        end
      end
      if (m_boot_left > 0) m_boot_left--;
    end
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    stall      = 1'b0;
    pc_mux_sel = 1'b0;
    jmp_loc    = 16'h0000;
    ready_drv  = 1'b1;
    @(posedge clk);
    #1;

    // Reset and boot
    repeat (3) cycle(0, 0, 0, 16'h0000, 1);
    repeat (6) cycle(1, 0, 0, 16'h0000, 1);

    // Memory wait states
    cycle(1, 0, 0, 16'h0000, 1);
    cycle(1, 0, 0, 16'h0000, 0);
    cycle(1, 0, 0, 16'h0000, 0);
    cycle(1, 0, 0, 16'h0000, 1);

    // Jump redirect
    cycle(1, 0, 1, 16'h0040, 1);
    repeat (3) cycle(1, 0, 0, 16'h0000, 1);

    // Stall, then redirect while stalled
    repeat (3) cycle(1, 1, 0, 16'h0000, 1);
    cycle(1, 1, 1, 16'hF000, 1);
    repeat (2) cycle(1, 0, 0, 16'h0000, 1);

    // PC wrap
    cycle(1, 0, 1, 16'hFFFF, 1);
    repeat (3) cycle(1, 0, 0, 16'h0000, 1);

    // Reset while stalled and redirecting, with redirect during boot
    cycle(0, 1, 1, 16'h1234, 1);
    cycle(1, 0, 1, 16'h0100, 1);
    repeat (6) cycle(1, 0, 0, 16'h0000, 1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      bit          r, st, sel, rdy;
      logic [15:0] jl;
      r   = ($urandom_range(0, 99) >= 2);
      st  = ($urandom_range(0, 4) == 0);
      sel = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      jl  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                        : 16'($urandom);
      cycle(r, st, sel, jl, rdy);
    end

    cycle(1, 0, 0, 16'h0000, 1);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
